// File: rtl/t07_esp_nibble_rx.sv
// ESP link receive stage: assembles MSB-first nibbles into 32-bit words, tags each
// word with a sequential register address and queues it in a small word FIFO that
// drains over a valid/ready handshake. Stalled partial words are discarded; words
// that find the FIFO full are dropped and flagged with a sticky error.
module t07_esp_nibble_rx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [3:0]                  ESP_in,
  input  logic                        ESP_valid,
  output logic [31:0]                 wordOut,
  output logic [$clog2(NUM_REGS)-1:0] wordAddr,
  output logic                        wordValid,
  input  logic                        wordReady,
  output logic                        busy,
  output logic                        overflowErr,
  output logic                        frameDone
);

  localparam int unsigned AW = $clog2(NUM_REGS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW = $clog2(TIMEOUT + 1);

  typedef enum logic {StIdle, StCollect} state_e;

  // Assembler state
  state_e        state_q;
  logic [2:0]    cnt_q;
  logic [27:0]   shift_q;
  logic [IW-1:0] idle_q;

  // Word FIFO state
  logic [31:0]   data_mem [FIFO_DEPTH];
  logic [AW-1:0] addr_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [OW-1:0] occ_q;
  logic [AW-1:0] addr_q;
  logic          ovf_q;
  logic          frame_done_q;

  logic          push_req;
  logic          push;
  logic          pop;
  logic          full;
  logic [31:0]   word_new;
  logic [AW-1:0] head_addr;

  // Handshake and push arbitration; a full FIFO still accepts when it pops this edge
  always_comb begin
    wordValid = (occ_q != '0);
    full      = (occ_q == OW'(FIFO_DEPTH));
    pop       = wordValid && wordReady;
    push_req  = ESP_valid && (cnt_q == 3'd7);
    push      = push_req && (!full || pop);
    word_new  = {shift_q, ESP_in};
    head_addr = addr_mem[rd_ptr_q];
    // Gate head outputs so stale storage is never visible when empty
    wordOut   = wordValid ? data_mem[rd_ptr_q] : '0;
    wordAddr  = wordValid ? head_addr : '0;
    busy      = (state_q == StCollect);
    overflowErr = ovf_q;
    frameDone   = frame_done_q;
  end

  // Assembler FSM: nibble shifting, word completion and mid-word timeout
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      idle_q  <= '0;
    end else if (ESP_valid) begin
      idle_q <= '0;
      if (cnt_q == 3'd7) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        shift_q <= '0;
      end else begin
        state_q <= StCollect;
        cnt_q   <= cnt_q + 3'd1;
        shift_q <= {shift_q[23:0], ESP_in};
      end
    end else if (state_q == StCollect) begin
      // The edge that would bring the idle count to TIMEOUT discards the partial word
      if (idle_q == IW'(TIMEOUT - 1)) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        shift_q <= '0;
        idle_q  <= '0;
      end else begin
        idle_q <= idle_q + IW'(1);
      end
    end
  end

  // FIFO pointers, occupancy, address counter and status flags
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      addr_q       <= '0;
      ovf_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        addr_q   <= (addr_q == AW'(NUM_REGS - 1)) ? '0 : addr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        occ_q <= occ_q + OW'(1);
      end else if (pop && !push) begin
        occ_q <= occ_q - OW'(1);
      end
      if (push_req && !push) begin
        ovf_q <= 1'b1;
      end
      frame_done_q <= pop && (head_addr == AW'(NUM_REGS - 1));
    end
  end

  // FIFO storage; contents are only observable through the gated head outputs
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= word_new;
      addr_mem[wr_ptr_q] <= addr_q;
    end
  end

endmodule

// File: tb/tb_t07_esp_nibble_rx.sv
// Scoreboard bench for t07_esp_nibble_rx: the stimulus pushes expected words,
// a negedge monitor pops and compares them whenever the DUT hands off a word.
module tb_t07_esp_nibble_rx;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [3:0]  ESP_in = '0;
  logic        ESP_valid = 1'b0;
  logic [31:0] wordOut;
  logic [4:0]  wordAddr;
  logic        wordValid;
  logic        wordReady = 1'b0;
  logic        busy;
  logic        overflowErr;
  logic        frameDone;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  a;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_errs = 0;
  int n_pops = 0;
  int n_valid_cyc = 0;
  int n_frame = 0;

  t07_esp_nibble_rx #(
    .FIFO_DEPTH(4),
    .NUM_REGS  (32),
    .TIMEOUT   (16)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .ESP_in     (ESP_in),
    .ESP_valid  (ESP_valid),
    .wordOut    (wordOut),
    .wordAddr   (wordAddr),
    .wordValid  (wordValid),
    .wordReady  (wordReady),
    .busy       (busy),
    .overflowErr(overflowErr),
    .frameDone  (frameDone)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a handoff is visible at negedge and completes on the next posedge
  always @(negedge clk) begin
    exp_t e;
    if (frameDone) n_frame++;
    if (wordValid) n_valid_cyc++;
    if (nrst && wordValid && wordReady) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_word: got %h addr %0d expected none", wordOut, wordAddr);
      end else begin
        e = exp_q.pop_front();
        check("word_data", wordOut, e.d);
        check("word_addr", 32'(wordAddr), 32'(e.a));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ESP_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [4:0] a);
    exp_q.push_back('{d: d, a: a});
  endtask

  // Sends nibbles first..first+n-1 of w (MSB first); optionally pops on the last edge
  task automatic send_nibbles(input logic [31:0] w, input int first, input int n,
                              input bit pop_last, output int nbusy);
    nbusy = 0;
    for (int i = first; i < first + n; i++) begin
      ESP_valid = 1'b1;
      ESP_in    = w[31-4*i -: 4];
      if (pop_last && i == first + n - 1) wordReady = 1'b1;
      tick();
      if (pop_last && i == first + n - 1) wordReady = 1'b0;
      if (busy) nbusy++;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    int nb;
    send_nibbles(w, 0, 8, 1'b0, nb);
  endtask

  task automatic do_reset();
    wordReady = 1'b0;
    ESP_valid = 1'b0;
    nrst      = 1'b0;
    tick();
    nrst      = 1'b1;
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wordOut"}, wordOut, 32'h0);
    check({tag, "_wordAddr"}, 32'(wordAddr), 32'h0);
    check({tag, "_wordValid"}, 32'(wordValid), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_overflowErr"}, 32'(overflowErr), 32'h0);
    check({tag, "_frameDone"}, 32'(frameDone), 32'h0);
  endtask

  logic [31:0] bp_words [6] = '{32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98,
                                32'h7654_3210, 32'h0000_0000, 32'hDEAD_BEEF};
  logic [31:0] fp_words [6] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003,
                                32'h4444_0004, 32'h5555_0005, 32'h6666_0006};

  initial begin
    int nb;

    // Reset state
    nrst = 1'b0;
    repeat (2) tick();
    check_zero("reset");
    nrst = 1'b1;
    tick();

    // Single word with consumer ready
    wordReady   = 1'b1;
    n_valid_cyc = 0;
    expect_word(32'hAABB_CCDD, 5'd0);
    send_nibbles(32'hAABB_CCDD, 0, 8, 1'b0, nb);
    idle(4);
    check("single_busy_cycles", 32'(nb), 32'd7);
    check("single_busy_after", 32'(busy), 32'd0);
    check("single_valid_cycles", 32'(n_valid_cyc), 32'd1);
    check("single_queue_empty", 32'(exp_q.size()), 32'd0);

    // Full frame: 32 back-to-back words plus one wrap
    do_reset();
    wordReady = 1'b1;
    n_frame   = 0;
    for (int i = 0; i < 33; i++) begin
      expect_word(32'hAABB_CCDD, 5'(i % 32));
      send_word(32'hAABB_CCDD);
    end
    idle(4);
    check("frame_done_pulses", 32'(n_frame), 32'd1);
    check("frame_overflow", 32'(overflowErr), 32'd0);
    check("frame_queue_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: 6 words into a 4-deep FIFO
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) expect_word(bp_words[i], 5'(i));
      send_word(bp_words[i]);
      if (i == 3) check("bp_ovf_after4", 32'(overflowErr), 32'd0);
      if (i == 4) check("bp_ovf_after5", 32'(overflowErr), 32'd1);
    end
    idle(2);
    check("bp_valid_held", 32'(wordValid), 32'd1);
    check("bp_head_stable", wordOut, 32'h0123_4567);
    n_pops    = 0;
    wordReady = 1'b1;
    idle(8);
    check("bp_drain_pops", 32'(n_pops), 32'd4);
    expect_word(32'h55AA_33CC, 5'd4);
    send_word(32'h55AA_33CC);
    idle(3);
    check("bp_total_pops", 32'(n_pops), 32'd5);
    check("bp_ovf_sticky", 32'(overflowErr), 32'd1);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Full FIFO with push and pop on the same edge
    do_reset();
    n_pops = 0;
    for (int i = 0; i < 4; i++) begin
      expect_word(fp_words[i], 5'(i));
      send_word(fp_words[i]);
    end
    expect_word(fp_words[4], 5'd4);
    send_nibbles(fp_words[4], 0, 8, 1'b1, nb);
    ESP_valid = 1'b0;
    check("fp_ovf_after_simul", 32'(overflowErr), 32'd0);
    check("fp_head_after_simul", wordOut, fp_words[1]);
    // Occupancy must still be 4, so a further word is dropped
    send_word(fp_words[5]);
    check("fp_ovf_when_full", 32'(overflowErr), 32'd1);
    wordReady = 1'b1;
    idle(8);
    check("fp_total_pops", 32'(n_pops), 32'd5);
    check("fp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Timeout discard then a clean word
    do_reset();
    wordReady = 1'b1;
    send_nibbles(32'h9ABC_D000, 0, 5, 1'b0, nb);
    idle(15);
    check("to_busy_before", 32'(busy), 32'd1);
    idle(1);
    check("to_busy_discard", 32'(busy), 32'd0);
    expect_word(32'h1234_5678, 5'd0);
    send_word(32'h1234_5678);
    idle(3);
    // Gap one short of the limit keeps the partial word
    expect_word(32'hCAFE_F00D, 5'd1);
    send_nibbles(32'hCAFE_F00D, 0, 5, 1'b0, nb);
    idle(15);
    check("to_var_busy", 32'(busy), 32'd1);
    send_nibbles(32'hCAFE_F00D, 5, 3, 1'b0, nb);
    idle(3);
    check("to_ovf", 32'(overflowErr), 32'd0);
    check("to_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset with queued words and a partial word in progress
    do_reset();
    send_word(32'hAAAA_0001);
    send_word(32'hAAAA_0002);
    send_nibbles(32'hAAAA_0003, 0, 3, 1'b0, nb);
    check("rst_pre_busy", 32'(busy), 32'd1);
    check("rst_pre_valid", 32'(wordValid), 32'd1);
    ESP_valid = 1'b0;
    nrst      = 1'b0;
    tick();
    check_zero("midrst");
    nrst = 1'b1;
    exp_q.delete();
    wordReady = 1'b1;
    expect_word(32'h0F1E_2D3C, 5'd0);
    send_word(32'h0F1E_2D3C);
    idle(3);
    check("rst_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/t07_esp_nibble_rx.md
# t07_esp_nibble_rx

Front-end receive stage for the team-07 top. Collects 4-bit nibbles from the ESP link, assembles them MSB-first into 32-bit words, and tags each word with a sequential register address. Completed words are buffered in a small FIFO and handed to the register-load logic over a valid/ready handshake. Partial words that stall are discarded, and words that arrive while the FIFO is full are dropped and flagged.

## Interface
Parameters:
- FIFO_DEPTH, 4: word-FIFO entries; must be a power of two and at least 2.
- NUM_REGS, 32: register-file size; the address counter wraps at this value.
- TIMEOUT, 16: idle cycles allowed mid-word before the partial word is discarded.

Ports:
- clk  in  1  system clock.
- nrst  in  1  reset, synchronous, active-low.
- ESP_in  in  4  nibble from the ESP link.
- ESP_valid  in  1  ESP_in is sampled on each rising edge where this is high.
- wordOut  out  32  head-of-FIFO word.
- wordAddr  out  $clog2(NUM_REGS)  register address of the head word.
- wordValid  out  1  FIFO is not empty.
- wordReady  in  1  consumer accepts the head word.
- busy  out  1  a partial word is in progress (nibble count is not 0).
- overflowErr  out  1  sticky; set when a completed word is dropped.
- frameDone  out  1  one-cycle pulse after the word with address NUM_REGS-1 is popped.

## Operation
- Reset (nrst low at a rising edge):
  - Outputs: wordOut=0, wordAddr=0, wordValid=0, busy=0, overflowErr=0, frameDone=0.
  - Internal: nibble count 0, shift register 0, idle counter 0, address counter 0, FIFO empty.
  - Reset overrides every other event, including mid-word and mid-handshake.
- Assembler states: IDLE (count=0) and COLLECT (count 1..7).
  - On each accepted nibble: shift = {shift[27:0], ESP_in}, count++.
  - On the 8th nibble: the completed word is {shift[27:0], ESP_in}. It is pushed to the FIFO with the current address, count returns to 0, and the state returns to IDLE.
- Address counter:
  - Increments only on a successful push; wraps NUM_REGS-1 -> 0.
  - Dropped words do not consume an address.
- Push rule:
  - A push succeeds if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflowErr is set. overflowErr clears only on reset.
- Pop: occurs on a rising edge where wordValid && wordReady. The head advances.
- Timeout:
  - In COLLECT, the idle counter increments on each cycle with ESP_valid=0 and clears on any accepted nibble.
  - When it reaches TIMEOUT, the partial word is discarded: count=0, shift=0, state IDLE, no push, no flag.
- Nibble value 0 is ordinary data. Only ESP_valid qualifies input.
- FIFO: circular buffer with wrapping read/write pointers and an occupancy count from 0 to FIFO_DEPTH. Storage is 32 data bits plus the address per entry.

## Timing
- Nibble sampled at edge N when ESP_valid=1. busy goes high after the first accepted nibble's edge and low after the 8th's edge.
- Word latency: when the 8th nibble is accepted at edge E with the FIFO empty, wordValid=1 and wordOut/wordAddr are valid after E, visible in cycle E+1.
- Throughput: one word per 8 cycles sustained. With wordReady held high, the FIFO never exceeds 1 entry.
- wordOut/wordAddr are held stable while wordValid=1 and wordReady=0.
- Push and pop in the same cycle leave occupancy unchanged, including when the FIFO is full.
- frameDone is high during the cycle after the pop edge of address NUM_REGS-1, otherwise 0.
- Timeout: with the last nibble at edge L and ESP_valid low afterwards, the discard occurs at edge L+TIMEOUT. A nibble accepted on or before edge L+TIMEOUT-1 continues the word.
- Reset mid-word or with a non-empty FIFO: all state is cleared at that edge, and no word from before reset ever appears.

## Test plan
- Single word: nibbles A,A,B,B,C,C,D,D on 8 consecutive cycles with wordReady=1.
  - wordValid pulses for 1 cycle with wordOut=0xAABBCCDD and wordAddr=0.
  - busy is high for 7 cycles.
- Full frame: 32 back-to-back words of 0xAABBCCDD with wordReady=1.
  - Addresses run 0..31.
  - frameDone pulses once after the addr-31 pop.
  - The 33rd word gets addr 0. overflowErr stays 0.
- Backpressure: wordReady=0 while 6 words are sent.
  - FIFO holds words with addr 0..3; wordValid stays high; overflowErr=1 after the 5th word.
  - Then wordReady=1: exactly 4 words pop, addr 0..3. The next received word gets addr 4.
- Full + simultaneous pop:
  - Setup: FIFO full, 8th nibble of a new word on the same edge as a pop.
  - Word is accepted, occupancy stays 4, overflowErr stays 0.
- Timeout:
  - 5 nibbles, then ESP_valid=0 for TIMEOUT cycles, then 8 nibbles 1..8 -> single word 0x12345678 at addr 0.
  - Variant: a gap of TIMEOUT-1 cycles, then 3 more nibbles -> the word completes from all 8 nibbles.
- Reset mid-operation:
  - Setup: 2 words queued with wordReady=0, 3 nibbles of a 3rd word accepted, then nrst low for 1 edge.
  - All outputs are 0 and busy=0.
  - The next word gets addr 0.
